// File: rtl/serin_shift_module_if.sv
// Signal bundle between the POKEY serial-input receiver and its host (timers, IRQ, SKSTAT).
// Handshake: data_ready rises when a byte lands in serin and holds until the host asserts irq_ack on an enp cycle; a new byte arriving first sets overrun.
interface serin_shift_module_if #(
  parameter int DATA_BITS = 8
);
  logic                 enp;
  logic                 bit_strobe;
  logic                 sid;
  logic                 async_mode;
  logic                 irq_ack;
  logic                 skres;
  logic [DATA_BITS-1:0] serin;
  logic                 data_ready;
  logic                 overrun;
  logic                 frame_err;
  logic                 busy;
  logic                 timer_rst;
  logic [1:0]           fsm_state;

  modport master (
    output enp, bit_strobe, sid, async_mode, irq_ack, skres,
    input  serin, data_ready, overrun, frame_err, busy, timer_rst, fsm_state
  );

  modport slave (
    input  enp, bit_strobe, sid, async_mode, irq_ack, skres,
    output serin, data_ready, overrun, frame_err, busy, timer_rst, fsm_state
  );
endinterface

// File: rtl/serin_shift_module.sv
// POKEY SIO serial-input receiver: start-bit detect, LSB-first shift-in, stop check,
// SERIN load and sticky ready/overrun/framing status.
module serin_shift_module #(
  parameter int DATA_BITS = 8
) (
  input logic                 clk,
  input logic                 reset,
  serin_shift_module_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic                 sid_m;
  logic                 sid_s;
  logic                 sid_d;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] serin_q;
  logic                 data_ready_q;
  logic                 overrun_q;
  logic                 frame_err_q;
  logic                 tick;
  logic                 timer_rst;
  logic                 shift_en;
  logic                 cnt_clr;
  logic                 stop_load;

  assign tick = bus.enp & bus.bit_strobe;

  // Synchronizer and edge-detect delay only advance on phase-enable cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sid_m <= 1'b1;
      sid_s <= 1'b1;
      sid_d <= 1'b1;
    end else if (bus.enp) begin
      sid_m <= bus.sid;
      sid_s <= sid_m;
      sid_d <= sid_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    timer_rst = 1'b0;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    stop_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.async_mode) begin
          if (bus.enp && sid_d && !sid_s) begin
            timer_rst = 1'b1;
            state_nx  = START;
          end
        end else if (tick && !sid_s) begin
          cnt_clr  = 1'b1;
          state_nx = DATA;
        end
      end
      START: begin
        if (tick) begin
          if (!sid_s) begin
            cnt_clr  = 1'b1;
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (cnt == CW'(DATA_BITS - 1)) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          stop_load = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;
      if (shift_en) shreg <= {sid_s, shreg[DATA_BITS-1:1]};
    end
  end

  // Clears are applied first so a same-cycle set overrides them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serin_q      <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (bus.enp) begin
      if (bus.irq_ack) data_ready_q <= 1'b0;
      if (bus.skres) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (stop_load) begin
        serin_q      <= shreg;
        data_ready_q <= 1'b1;
        if (data_ready_q) overrun_q <= 1'b1;
        if (!sid_s) frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.serin      = serin_q;
  assign bus.data_ready = data_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state != IDLE);
  assign bus.timer_rst  = timer_rst;
  assign bus.fsm_state  = state;
endmodule

// File: tb/tb_serin_shift_module.sv
// Bench for serin_shift_module: directed frames with literal expectations, then random
// traffic, all checked every cycle against a frame-level sample-collecting model.
module tb_serin_shift_module;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tr_count = 0;

  serin_shift_module_if bus ();

  serin_shift_module dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A frame is a list of samples taken on ticks: start, 8 data (LSB first), stop.
  logic [7:0] m_serin = 8'h00;
  bit         m_dr = 0, m_ov = 0, m_fe = 0, m_busy = 0;
  bit         hist[$] = '{1'b1, 1'b1, 1'b1};
  bit         bits[$];
  bit         set_dr, set_ov, set_fe, s_now, d_now;
  logic [7:0] v;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_serin = 8'h00; m_dr = 0; m_ov = 0; m_fe = 0; m_busy = 0;
      hist = '{1'b1, 1'b1, 1'b1};
      bits.delete();
    end else if (bus.enp) begin
      set_dr = 0; set_ov = 0; set_fe = 0;
      s_now = hist[1];
      d_now = hist[2];
      if (!m_busy) begin
        if (bus.async_mode) begin
          if (d_now && !s_now) begin
            m_busy = 1;
            bits.delete();
          end
        end else if (bus.bit_strobe && !s_now) begin
          m_busy = 1;
          bits.delete();
          bits.push_back(1'b0);
        end
      end else if (bus.bit_strobe) begin
        bits.push_back(s_now);
        if (bits.size() == 1 && s_now) begin
          m_busy = 0;
        end else if (bits.size() == 10) begin
          for (int i = 0; i < 8; i++) v[i] = bits[i+1];
          set_dr = 1;
          set_ov = m_dr;
          set_fe = !s_now;
          m_serin = v;
          m_busy = 0;
        end
      end
      if (bus.irq_ack) m_dr = 0;
      if (bus.skres) begin m_ov = 0; m_fe = 0; end
      if (set_dr) m_dr = 1;
      if (set_ov) m_ov = 1;
      if (set_fe) m_fe = 1;
      hist.push_front(bus.sid);
      void'(hist.pop_back());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("serin", 32'(bus.serin), 32'(m_serin));
      chk("data_ready", 32'(bus.data_ready), 32'(m_dr));
      chk("overrun", 32'(bus.overrun), 32'(m_ov));
      chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("timer_rst", 32'(bus.timer_rst),
          32'(!m_busy && bus.async_mode && bus.enp && hist[2] && !hist[1]));
      if (bus.timer_rst) tr_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit ack_at_tick);
    for (int i = 0; i < 16; i++) begin
      step();
      bus.sid        = b;
      bus.bit_strobe = (i == 8);
      bus.irq_ack    = ack_at_tick && (i == 8);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit ack_stop);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(data[i], 0);
    send_bit(stop, ack_stop);
    send_bit(1'b1, 0);
  endtask

  task automatic clear_flags();
    step();
    bus.irq_ack = 1'b1;
    bus.skres   = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    bus.skres   = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge clk);
    chk(name, act, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;
    bus.enp = 1'b1; bus.bit_strobe = 1'b0; bus.sid = 1'b1; bus.async_mode = 1'b0;
    bus.irq_ack = 1'b0; bus.skres = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_serin", 32'(bus.serin), 32'h0);
    chk("rst_dr", 32'(bus.data_ready), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_tr", 32'(bus.timer_rst), 32'h0);
    step();
    reset = 1'b0;
    send_bit(1'b1, 0);

    // 1: async frame 0xA5
    bus.async_mode = 1'b1;
    tr_count = 0;
    send_frame(8'hA5, 1'b1, 0);
    lit("t1_serin", 32'(bus.serin), 32'hA5);
    lit("t1_dr", 32'(bus.data_ready), 32'h1);
    lit("t1_fe", 32'(bus.frame_err), 32'h0);
    lit("t1_ov", 32'(bus.overrun), 32'h0);
    lit("t1_busy", 32'(bus.busy), 32'h0);
    lit("t1_pulses", 32'(tr_count), 32'h1);

    // 2: back-to-back frames without irq_ack, sync mode
    clear_flags();
    bus.async_mode = 1'b0;
    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 0);
    lit("t2_serin", 32'(bus.serin), 32'hC3);
    lit("t2_ov", 32'(bus.overrun), 32'h1);
    step(); bus.skres = 1'b1; step(); bus.skres = 1'b0;
    lit("t2_ov_clr", 32'(bus.overrun), 32'h0);
    lit("t2_dr_kept", 32'(bus.data_ready), 32'h1);

    // 3: framing error, sticky across a good frame
    clear_flags();
    send_frame(8'hFF, 1'b0, 0);
    lit("t3_serin", 32'(bus.serin), 32'hFF);
    lit("t3_fe", 32'(bus.frame_err), 32'h1);
    send_frame(8'h11, 1'b1, 0);
    lit("t3_serin2", 32'(bus.serin), 32'h11);
    lit("t3_fe_sticky", 32'(bus.frame_err), 32'h1);
    step(); bus.skres = 1'b1; step(); bus.skres = 1'b0;
    lit("t3_fe_clr", 32'(bus.frame_err), 32'h0);

    // 4: async false start
    clear_flags();
    bus.async_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      bus.sid        = (i >= 6);
      bus.bit_strobe = (i == 8);
    end
    send_bit(1'b1, 0);
    lit("t4_dr", 32'(bus.data_ready), 32'h0);
    lit("t4_serin", 32'(bus.serin), 32'h11);
    lit("t4_busy", 32'(bus.busy), 32'h0);

    // 5: reset after the 4th data bit, then a clean frame
    pat = 8'h5A;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(pat[i], 0);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    lit("t5_serin", 32'(bus.serin), 32'h0);
    lit("t5_dr", 32'(bus.data_ready), 32'h0);
    lit("t5_busy", 32'(bus.busy), 32'h0);
    lit("t5_fe_ov", 32'({bus.frame_err, bus.overrun}), 32'h0);
    bus.sid = 1'b1;
    send_bit(1'b1, 0);
    send_frame(8'h5A, 1'b1, 0);
    lit("t5_serin2", 32'(bus.serin), 32'h5A);
    lit("t5_dr2", 32'(bus.data_ready), 32'h1);

    // 6: irq_ack on the stop tick, then strobes with enp low
    clear_flags();
    bus.async_mode = 1'b0;
    send_frame(8'h96, 1'b1, 1);
    lit("t6_serin", 32'(bus.serin), 32'h96);
    lit("t6_dr_setwins", 32'(bus.data_ready), 32'h1);
    step();
    bus.enp = 1'b0; bus.bit_strobe = 1'b1; bus.sid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    lit("t6_no_adv", 32'(bus.busy), 32'h0);
    bus.bit_strobe = 1'b0; bus.sid = 1'b1; bus.enp = 1'b1;
    send_bit(1'b1, 0);
    lit("t6_idle", 32'(bus.busy), 32'h0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      bus.enp        = (($urandom_range(0, 3)) != 0);
      bus.bit_strobe = (($urandom_range(0, 5)) == 0);
      if ($urandom_range(0, 5) == 0) bus.sid = ~bus.sid;
      bus.irq_ack    = (($urandom_range(0, 29)) == 0);
      bus.skres      = (($urandom_range(0, 39)) == 0);
      if ($urandom_range(0, 199) == 0) bus.async_mode = ~bus.async_mode;
      reset          = (($urandom_range(0, 599)) == 0);
    end
    step();
    reset = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
